sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 85 ++++++++
 tb/tb_sync_fifo_param.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO: binary pointers with one extra wrap bit, registered
// read data with a one-cycle valid pulse, and sticky overflow/underflow.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Status flags and occupancy depend only on the registered pointers.
    always_comb begin
        empty        = (wptr == rptr);
        full         = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                       (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
        count        = wptr - rptr;
        almost_full  = (int'(count) >= AF_LEVEL);
        almost_empty = (int'(count) <= AE_LEVEL);
    end

    // Accept logic: a read never sees a same-cycle write, but a write into a
    // full FIFO is allowed when a read frees a slot on the same edge.
    always_comb begin
        rd_ok = r_en && !empty;
        wr_ok = w_en && (!full || rd_ok);
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= w_data;
        end
    end

    // Pointers, read data register and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            r_valid <= rd_ok;
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                r_data <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr   <= rptr + PTR_ONE;
            end
            if (w_en && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param with default parameters (depth 8).
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_en = 1'b0;
    logic [31:0] w_data = '0;
    logic        r_en = 1'b0;
    logic [31:0] r_data;
    logic        r_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int passed = 0;

    sync_fifo_param dut (
        .clk          (clk),
        .reset        (reset),
        .w_en         (w_en),
        .w_data       (w_data),
        .r_en         (r_en),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic cycle(input logic we, input logic [31:0] wd, input logic re);
        w_en   = we;
        w_data = wd;
        r_en   = re;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++; if (empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", empty); else passed++;
        checks++; if (full !== 1'b0) $display("FAIL rst_full got=%b exp=0", full); else passed++;
        checks++; if (count !== 4'd0) $display("FAIL rst_count got=%0d exp=0", count); else passed++;
        checks++; if (almost_empty !== 1'b1) $display("FAIL rst_ae got=%b exp=1", almost_empty); else passed++;
        checks++; if (almost_full !== 1'b0) $display("FAIL rst_af got=%b exp=0", almost_full); else passed++;
        checks++; if (r_data !== 32'd0) $display("FAIL rst_rdata got=%0h exp=0", r_data); else passed++;
        checks++; if (r_valid !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", r_valid); else passed++;
        checks++; if ({overflow, underflow} !== 2'b00) $display("FAIL rst_err got=%b exp=00", {overflow, underflow}); else passed++;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'(i), 1'b0);
            checks++; if (count !== 4'(i + 1)) $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); else passed++;
            checks++; if (almost_full !== (i >= 6)) $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, i >= 6); else passed++;
            checks++; if (almost_empty !== (i == 0)) $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, i == 0); else passed++;
            checks++; if (full !== (i == 7)) $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 7); else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'd0, 1'b1);
            checks++; if (r_valid !== 1'b1) $display("FAIL drain_rvalid[%0d] got=%b exp=1", i, r_valid); else passed++;
            checks++; if (r_data !== 32'(i)) $display("FAIL drain_rdata[%0d] got=%0h exp=%0h", i, r_data, i); else passed++;
        end
        checks++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else passed++;
        cycle(1'b0, 32'd0, 1'b0);
        checks++; if (r_valid !== 1'b0) $display("FAIL idle_rvalid got=%b exp=0", r_valid); else passed++;
        checks++; if (r_data !== 32'd7) $display("FAIL idle_rdata_hold got=%0h exp=7", r_data); else passed++;
        checks++; if ({overflow, underflow} !== 2'b00) $display("FAIL fill_err got=%b exp=00", {overflow, underflow}); else passed++;
    endtask

    task automatic test_overflow_and_simul();
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
        cycle(1'b1, 32'hDEAD, 1'b0);
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else passed++;
        checks++; if (count !== 4'd8) $display("FAIL ovf_count got=%0d exp=8", count); else passed++;
        checks++; if (full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", full); else passed++;
        // full with simultaneous read and write
        cycle(1'b1, 32'hB0, 1'b1);
        checks++; if (r_valid !== 1'b1 || r_data !== 32'hA0) $display("FAIL simul_read got=%b/%0h exp=1/a0", r_valid, r_data); else passed++;
        checks++; if (count !== 4'd8) $display("FAIL simul_count got=%0d exp=8", count); else passed++;
        checks++; if (full !== 1'b1) $display("FAIL simul_full got=%b exp=1", full); else passed++;
        for (int i = 1; i < 9; i++) begin
            cycle(1'b0, 32'd0, 1'b1);
            checks++; if (r_data !== ((i < 8) ? 32'hA0 + 32'(i) : 32'hB0)) $display("FAIL ovf_order[%0d] got=%0h exp=%0h", i, r_data, (i < 8) ? 32'hA0 + 32'(i) : 32'hB0); else passed++;
        end
        checks++; if (empty !== 1'b1) $display("FAIL ovf_drain_empty got=%b exp=1", empty); else passed++;
        checks++; if (overflow !== 1'b1 || underflow !== 1'b0) $display("FAIL ovf_sticky got=%b%b exp=10", overflow, underflow); else passed++;
    endtask

    task automatic test_empty_read();
        cycle(1'b1, 32'hC0, 1'b1);
        checks++; if (r_valid !== 1'b0) $display("FAIL eread_rvalid got=%b exp=0", r_valid); else passed++;
        checks++; if (r_data !== 32'hB0) $display("FAIL eread_rdata_hold got=%0h exp=b0", r_data); else passed++;
        checks++; if (underflow !== 1'b1) $display("FAIL eread_uflow got=%b exp=1", underflow); else passed++;
        checks++; if (count !== 4'd1) $display("FAIL eread_count got=%0d exp=1", count); else passed++;
        cycle(1'b0, 32'd0, 1'b1);
        checks++; if (r_valid !== 1'b1 || r_data !== 32'hC0) $display("FAIL eread_data got=%b/%0h exp=1/c0", r_valid, r_data); else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'd100 + 32'(i), 1'b0);
            checks++; if (count !== 4'd1) $display("FAIL wrap_count[%0d] got=%0d exp=1", i, count); else passed++;
            cycle(1'b0, 32'd0, 1'b1);
            checks++; if (r_data !== 32'd100 + 32'(i)) $display("FAIL wrap_data[%0d] got=%0d exp=%0d", i, r_data, 100 + i); else passed++;
            checks++; if (empty !== 1'b1) $display("FAIL wrap_empty[%0d] got=%b exp=1", i, empty); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hD0 + 32'(i), 1'b0);
        checks++; if (count !== 4'd5) $display("FAIL mid_pre_count got=%0d exp=5", count); else passed++;
        #2 reset = 1'b1;
        #1;
        checks++; if (empty !== 1'b1) $display("FAIL mid_empty got=%b exp=1", empty); else passed++;
        checks++; if (count !== 4'd0) $display("FAIL mid_count got=%0d exp=0", count); else passed++;
        checks++; if (r_data !== 32'd0) $display("FAIL mid_rdata got=%0h exp=0", r_data); else passed++;
        checks++; if ({overflow, underflow} !== 2'b00) $display("FAIL mid_err got=%b exp=00", {overflow, underflow}); else passed++;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (empty !== 1'b1) $display("FAIL mid_post_empty got=%b exp=1", empty); else passed++;
        cycle(1'b1, 32'hE5, 1'b0);
        cycle(1'b0, 32'd0, 1'b1);
        checks++; if (r_valid !== 1'b1 || r_data !== 32'hE5) $display("FAIL mid_new_data got=%b/%0h exp=1/e5", r_valid, r_data); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL mid_final_empty got=%b exp=1", empty); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_and_simul();
        test_empty_read();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
